// File: rtl/parity_stream_gen.sv
// parity_stream_gen: even/odd parity over framed DATA_W-bit words, one word per
// accepted beat. Generate mode emits the frame parity; check mode also compares
// it with a received parity bit and flags a mismatch.
// Optional PARITY_ERRCNT_EN builds a saturating mismatch counter (err_count,
// err_clr); without it err_count is tied to 0 and err_clr is ignored.
module parity_stream_gen #(
    parameter int unsigned DATA_W = 8,
    parameter bit          ODD    = 1'b0,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              mode,
    input  logic              in_parity,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_parity,
    output logic              out_err,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  err_count
);

    typedef enum logic {StAcc, StHold} state_t;

    state_t state_q, state_d;
    logic   acc_q;
    logic   first_q;
    logic   mode_q;
    logic   out_parity_q;
    logic   out_err_q;

    logic beat;
    logic word_par;
    logic frame_par;
    logic eff_mode;
    logic mismatch;

    assign beat      = in_valid & in_ready;
    assign word_par  = ^in_data;
    assign frame_par = acc_q ^ word_par ^ ODD;
    // A single-beat frame has not latched mode yet, so use the live input.
    assign eff_mode  = first_q ? mode : mode_q;
    assign mismatch  = eff_mode & (frame_par != in_parity);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StAcc;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: close a frame on its last beat, release on result handshake
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAcc:   if (beat && in_last) state_d = StHold;
            StHold:  if (out_ready)       state_d = StAcc;
            default: state_d = StAcc;
        endcase
    end

    // Outputs: accept beats only while accumulating, present result while holding
    always_comb begin
        in_ready  = (state_q == StAcc);
        out_valid = (state_q == StHold);
    end

    // Datapath: accumulate word parities and capture the frame result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= 1'b0;
            first_q      <= 1'b1;
            mode_q       <= 1'b0;
            out_parity_q <= 1'b0;
            out_err_q    <= 1'b0;
        end else if (beat) begin
            if (first_q) begin
                mode_q <= mode;
            end
            if (in_last) begin
                out_parity_q <= frame_par;
                out_err_q    <= mismatch;
                acc_q        <= 1'b0;
                first_q      <= 1'b1;
            end else begin
                acc_q   <= acc_q ^ word_par;
                first_q <= 1'b0;
            end
        end
    end

    assign out_parity = out_parity_q;
    assign out_err    = out_err_q;

`ifdef PARITY_ERRCNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating mismatch counter; clear takes priority over an increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (err_clr) begin
            cnt_q <= '0;
        end else if (beat && in_last && mismatch && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign err_count = cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_parity_stream_gen.sv
// Directed bench for parity_stream_gen. Two instances share the stimulus:
// dut0 uses even parity with a 2-bit counter, dut1 odd parity with 8 bits.
module tb_parity_stream_gen;

`ifdef PARITY_ERRCNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       mode;
    logic       in_parity;
    logic       out_ready;
    logic       err_clr;

    logic       in_ready0, out_valid0, out_parity0, out_err0;
    logic [1:0] err_count0;
    logic       in_ready1, out_valid1, out_parity1, out_err1;
    logic [7:0] err_count1;

    int vectors;
    int errors;

    parity_stream_gen #(.DATA_W(8), .ODD(1'b0), .CNT_W(2)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready0),
        .in_data    (in_data),
        .in_last    (in_last),
        .mode       (mode),
        .in_parity  (in_parity),
        .out_valid  (out_valid0),
        .out_ready  (out_ready),
        .out_parity (out_parity0),
        .out_err    (out_err0),
        .err_clr    (err_clr),
        .err_count  (err_count0)
    );

    parity_stream_gen #(.DATA_W(8), .ODD(1'b1), .CNT_W(8)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready1),
        .in_data    (in_data),
        .in_last    (in_last),
        .mode       (mode),
        .in_parity  (in_parity),
        .out_valid  (out_valid1),
        .out_ready  (out_ready),
        .out_parity (out_parity1),
        .out_err    (out_err1),
        .err_clr    (err_clr),
        .err_count  (err_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic last, input logic md, input logic par);
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        mode      = md;
        in_parity = par;
        step();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 8'h00;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("consume in_ready0", {31'b0, in_ready0}, 32'd1);
        check("consume out_valid0", {31'b0, out_valid0}, 32'd0);
    endtask

    function automatic logic [31:0] cnt(input int n);
        return CntEn ? n : 0;
    endfunction

    initial begin
        vectors   = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        mode      = 1'b0;
        in_parity = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        step();
        step();

        // Reset state
        check("rst in_ready", {31'b0, in_ready0}, 32'd1);
        check("rst out_valid", {31'b0, out_valid0}, 32'd0);
        check("rst out_parity", {31'b0, out_parity0}, 32'd0);
        check("rst out_err", {31'b0, out_err0}, 32'd0);
        check("rst err_count", {30'b0, err_count0}, 32'd0);
        rst = 1'b0;
        step();

        // Generate, single beat 0x07 (3 ones)
        beat(8'h07, 1'b1, 1'b0, 1'b0);
        check("gen1 out_valid", {31'b0, out_valid0}, 32'd1);
        check("gen1 in_ready", {31'b0, in_ready0}, 32'd0);
        check("gen1 parity even", {31'b0, out_parity0}, 32'd1);
        check("gen1 parity odd", {31'b0, out_parity1}, 32'd0);
        check("gen1 out_err", {31'b0, out_err0}, 32'd0);
        consume();

        // Generate, three beats, 11 ones
        beat(8'h01, 1'b0, 1'b0, 1'b0);
        check("gen3 mid out_valid", {31'b0, out_valid0}, 32'd0);
        beat(8'h03, 1'b0, 1'b0, 1'b0);
        beat(8'hFF, 1'b1, 1'b0, 1'b0);
        check("gen3 out_valid", {31'b0, out_valid0}, 32'd1);
        check("gen3 parity even", {31'b0, out_parity0}, 32'd1);
        check("gen3 parity odd", {31'b0, out_parity1}, 32'd0);
        consume();

        // Check mode, 0xF0 with in_parity=1: even instance mismatches
        beat(8'hF0, 1'b1, 1'b1, 1'b1);
        check("chk1 parity even", {31'b0, out_parity0}, 32'd0);
        check("chk1 err even", {31'b0, out_err0}, 32'd1);
        check("chk1 cnt even", {30'b0, err_count0}, cnt(1));
        check("chk1 parity odd", {31'b0, out_parity1}, 32'd1);
        check("chk1 err odd", {31'b0, out_err1}, 32'd0);
        check("chk1 cnt odd", {24'b0, err_count1}, 32'd0);
        consume();

        // Same frame with in_parity=0: odd instance mismatches instead
        beat(8'hF0, 1'b1, 1'b1, 1'b0);
        check("chk2 err even", {31'b0, out_err0}, 32'd0);
        check("chk2 cnt even", {30'b0, err_count0}, cnt(1));
        check("chk2 err odd", {31'b0, out_err1}, 32'd1);
        check("chk2 cnt odd", {24'b0, err_count1}, cnt(1));
        consume();

        // Mode taken from the first beat: check frame, mode dropped on last beat
        beat(8'h01, 1'b0, 1'b1, 1'b1);
        beat(8'h00, 1'b1, 1'b0, 1'b0);
        check("modelatch chk err", {31'b0, out_err0}, 32'd1);
        check("modelatch chk cnt", {30'b0, err_count0}, cnt(2));
        consume();

        // Generate frame, mode raised on last beat: must stay generate
        beat(8'h01, 1'b0, 1'b0, 1'b1);
        beat(8'h00, 1'b1, 1'b1, 1'b0);
        check("modelatch gen err", {31'b0, out_err0}, 32'd0);
        check("modelatch gen cnt", {30'b0, err_count0}, cnt(2));
        consume();

        // Backpressure: result held 5 cycles while a stray beat is offered
        beat(8'h03, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hFE;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp out_valid", {31'b0, out_valid0}, 32'd1);
            check("bp in_ready", {31'b0, in_ready0}, 32'd0);
            check("bp parity even", {31'b0, out_parity0}, 32'd0);
            check("bp parity odd", {31'b0, out_parity1}, 32'd1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        consume();
        step();
        check("bp idle out_valid", {31'b0, out_valid0}, 32'd0);

        // Saturation with CNT_W=2: clear, then five erroring frames
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr cnt even", {30'b0, err_count0}, 32'd0);
        check("clr cnt odd", {24'b0, err_count1}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            beat(8'hF0, 1'b1, 1'b1, 1'b1);
            check("sat cnt even", {30'b0, err_count0}, cnt((i > 3) ? 3 : i));
            check("sat cnt odd", {24'b0, err_count1}, 32'd0);
            consume();
        end
        // Sixth error with clear in the same cycle: clear wins
        err_clr = 1'b1;
        beat(8'hF0, 1'b1, 1'b1, 1'b1);
        err_clr = 1'b0;
        check("clrwin err", {31'b0, out_err0}, 32'd1);
        check("clrwin cnt", {30'b0, err_count0}, 32'd0);
        consume();

        // One more error so the abort below also shows the counter reset
        beat(8'hF0, 1'b1, 1'b1, 1'b1);
        check("pre-abort cnt", {30'b0, err_count0}, cnt(1));
        consume();

        // Abort a 4-beat frame after 2 beats (running parity 1)
        beat(8'h01, 1'b0, 1'b0, 1'b0);
        beat(8'h03, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("abort out_valid", {31'b0, out_valid0}, 32'd0);
        check("abort cnt", {30'b0, err_count0}, 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort no result", {31'b0, out_valid0 | out_valid1}, 32'd0);
        end
        beat(8'h01, 1'b1, 1'b0, 1'b0);
        check("fresh out_valid", {31'b0, out_valid0}, 32'd1);
        check("fresh parity even", {31'b0, out_parity0}, 32'd1);
        check("fresh parity odd", {31'b0, out_parity1}, 32'd0);
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
